ring_in_dest_ctrl: RTL
======================

# ring_in_dest_ctrl

Ingress stage for one ring node: accepts flits arriving from the upstream ring link, decodes the head flit of each message into a destination FIFO (pass/local × req/rep), holds that selection for the body and tail flits, and presents a registered flit/ctrl/dest_fifo/en_dest_fifo bundle to the 4-way enqueue arbiter. It applies per-FIFO backpressure, so a flit is only enabled into a FIFO that has room. It sits directly upstream of arbiter_4_enq.

## Interface
- NODE_ID, 2'b00, ring address of this node; a head flit whose dest field equals NODE_ID goes to the local in FIFOs.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flit_in  in  16  flit from upstream link.
- ctrl_in  in  2  00 idle/invalid, 01 head, 10 body, 11 tail.
- ready_out  out  1  upstream may transfer; transfer occurs when ctrl_in!=00 && ready_out.
- pass_req_full, pass_rep_full, local_in_req_full, local_in_rep_full  in  1 each  full flags of the four target FIFOs.
- flit  out  16  registered flit to arbiter.
- ctrl  out  2  registered ctrl to arbiter.
- dest_fifo  out  2  00 pass req, 01 pass rep, 10 local in req, 11 local in rep.
- en_dest_fifo  out  1  write enable to arbiter; high only when stage valid and selected FIFO not full.
- proto_err  out  1  one-cycle pulse on protocol violation.

## Operation
- Head flit field map: flit_in[15:14] dest node id, flit_in[13] type (0 req, 1 rep); remaining bits opaque.
- Head decode: dest_fifo = {flit_in[15:14]==NODE_ID, flit_in[13]}.
- FSM: IDLE (awaiting head), IN_MSG (dest latched in msg_dest register).
  - IDLE + accepted head -> IN_MSG, msg_dest <= decoded dest.
  - IN_MSG + accepted body -> IN_MSG, uses msg_dest.
  - IN_MSG + accepted tail -> IDLE, uses msg_dest.
  - IN_MSG + accepted head -> stays IN_MSG, new dest latched, proto_err pulse; head is forwarded (old message truncated).
  - IDLE + accepted body/tail -> flit dropped (not loaded into stage), proto_err pulse, stay IDLE.
- Every message is ≥2 flits; single-flit messages are not supported.
- Output stage: one register (stage_valid, flit, ctrl, dest_fifo).
  - sel_full = full flag selected by stage dest_fifo.
  - en_dest_fifo = stage_valid && !sel_full (combinational on full flags).
  - ready_out = !stage_valid || en_dest_fifo.
  - On accepted non-dropped flit: stage loads new flit/ctrl/dest, stage_valid <= 1.
  - Else if en_dest_fifo: stage_valid <= 0, ctrl <= 00.
- Dropped flits still consume a ready_out handshake (upstream is never stalled by an error).
- ctrl output is 00 whenever stage_valid=0; flit holds last value.

## Timing
- Reset values: flit 16'h0000, ctrl 00, dest_fifo 00, en_dest_fifo 0, proto_err 0, stage_valid 0, FSM IDLE, msg_dest 00; ready_out=1 immediately after reset.
- Latency: flit accepted at edge N appears on flit/ctrl/dest_fifo after edge N; en_dest_fifo high in cycle N+1 if target not full.
- Throughput: one flit per cycle when target FIFO never full (load and drain same edge).
- Target full: stage holds, en_dest_fifo=0, ready_out=0; no flit lost, no duplicate write. Release of full flag enables write same cycle.
- Full flags of non-selected FIFOs have no effect.
- proto_err asserted in the cycle after the offending transfer edge, for exactly one cycle.
- Reset mid-message: stage emptied, FSM IDLE; a following body/tail is dropped with proto_err.

## Test plan
- NODE_ID=01, no full: head 16'h4001 (dest 01, req), body 16'h0002, tail 16'h0003 back-to-back -> three consecutive cycles en_dest_fifo=1, dest_fifo=10, ctrl 01/10/11.
- Head 16'h2000 (dest 00, rep) + tail -> dest_fifo=01 both flits; FSM returns IDLE.
- Head to pass req, pass_req_full=1 for 3 cycles while body pending -> en_dest_fifo=0 and ready_out=0 for 3 cycles, head written once on release, body follows next cycle.
- local_in_rep_full=1 during message to pass req -> no stall, full flits delivered.
- Body 16'h1234 in IDLE -> dropped, proto_err=1 one cycle, en_dest_fifo stays 0; head 16'h6000 mid-message -> forwarded with dest_fifo 11, proto_err pulse.
- Assert rst after head accepted, release, send tail -> outputs at reset values, tail dropped with proto_err.

Source files
------------

// File: rtl/ring_in_dest_ctrl.sv
// Ring ingress stage: decodes each message's head flit into one of four destination FIFOs
// and presents a single registered flit/ctrl/dest bundle with per-FIFO backpressure.
module ring_in_dest_ctrl #(
    parameter logic [1:0] NODE_ID = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] flit_in,
    input  logic [1:0]  ctrl_in,
    output logic        ready_out,
    input  logic        pass_req_full,
    input  logic        pass_rep_full,
    input  logic        local_in_req_full,
    input  logic        local_in_rep_full,
    output logic [15:0] flit,
    output logic [1:0]  ctrl,
    output logic [1:0]  dest_fifo,
    output logic        en_dest_fifo,
    output logic        proto_err
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_MSG = 1'b1
    } state_t;

    localparam logic [1:0] CTRL_IDLE = 2'b00;
    localparam logic [1:0] CTRL_HEAD = 2'b01;
    localparam logic [1:0] CTRL_TAIL = 2'b11;

    state_t      state_q, state_d;
    logic [1:0]  msg_dest_q, msg_dest_d;
    logic        stage_valid_q, stage_valid_d;
    logic [15:0] flit_q, flit_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [1:0]  dest_q, dest_d;
    logic        proto_err_q, proto_err_d;

    logic        sel_full_s;
    logic        en_s;
    logic        accept_s;
    logic        is_head_s;
    logic        drop_s;
    logic        load_s;
    logic [1:0]  head_dest_s;

    // Full flag of the FIFO the staged flit is aimed at
    always_comb begin
        case (dest_q)
            2'b00:   sel_full_s = pass_req_full;
            2'b01:   sel_full_s = pass_rep_full;
            2'b10:   sel_full_s = local_in_req_full;
            2'b11:   sel_full_s = local_in_rep_full;
            default: sel_full_s = 1'b1;
        endcase
    end

    assign en_s        = stage_valid_q && !sel_full_s;
    assign ready_out   = !stage_valid_q || en_s;
    assign accept_s    = (ctrl_in != CTRL_IDLE) && ready_out;
    assign is_head_s   = (ctrl_in == CTRL_HEAD);
    // Body/tail with no open message is swallowed so upstream never stalls on an error
    assign drop_s      = accept_s && (state_q == ST_IDLE) && !is_head_s;
    assign load_s      = accept_s && !drop_s;
    assign head_dest_s = {(flit_in[15:14] == NODE_ID), flit_in[13]};

    // Message framing FSM and protocol error detection
    always_comb begin
        state_d     = state_q;
        msg_dest_d  = msg_dest_q;
        proto_err_d = 1'b0;
        if (accept_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_head_s) begin
                        state_d    = ST_IN_MSG;
                        msg_dest_d = head_dest_s;
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
                ST_IN_MSG: begin
                    if (is_head_s) begin
                        msg_dest_d  = head_dest_s;
                        proto_err_d = 1'b1;
                    end else if (ctrl_in == CTRL_TAIL) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_IN_MSG;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output stage: load and drain may coincide for full throughput
    always_comb begin
        stage_valid_d = stage_valid_q;
        flit_d        = flit_q;
        ctrl_d        = ctrl_q;
        dest_d        = dest_q;
        if (load_s) begin
            stage_valid_d = 1'b1;
            flit_d        = flit_in;
            ctrl_d        = ctrl_in;
            dest_d        = is_head_s ? head_dest_s : msg_dest_q;
        end else if (en_s) begin
            stage_valid_d = 1'b0;
            ctrl_d        = CTRL_IDLE;
        end else begin
            stage_valid_d = stage_valid_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            msg_dest_q    <= 2'b00;
            stage_valid_q <= 1'b0;
            flit_q        <= 16'h0000;
            ctrl_q        <= 2'b00;
            dest_q        <= 2'b00;
            proto_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            msg_dest_q    <= msg_dest_d;
            stage_valid_q <= stage_valid_d;
            flit_q        <= flit_d;
            ctrl_q        <= ctrl_d;
            dest_q        <= dest_d;
            proto_err_q   <= proto_err_d;
        end
    end

    assign flit         = flit_q;
    assign ctrl         = ctrl_q;
    assign dest_fifo    = dest_q;
    assign en_dest_fifo = en_s;
    assign proto_err    = proto_err_q;

endmodule
